// File: rtl/mp3player_soc_input_pio.sv
// Avalon-MM input PIO: synchronised (optionally debounced) level register, edge capture
// with write-1-to-clear, and masked interrupt. Debounce enabled by MP3PLAYER_SOC_INPUT_PIO_DEBOUNCE_EN.
module mp3player_soc_input_pio #(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] ec_clear;
  logic [31:0]      rd_mux;
  logic             wr_en;

  // Only the low WIDTH bits of writedata carry register contents.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef MP3PLAYER_SOC_INPUT_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] db_cnt;
  logic [WIDTH-1:0]            stable_q;

  // A bit only follows sync after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable_q[i] <= sync[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign stable = stable_q;
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign stable = sync;
`endif

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = stable & ~prev;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~stable & prev;
    end else begin : g_any
      assign edge_det = stable ^ prev;
    end
  endgenerate

  assign wr_en    = chipselect && !write_n;
  assign ec_clear = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Set is ORed in after the clear so a coincident edge keeps the bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      prev        <= stable;
      edgecapture <= (edgecapture & ~ec_clear) | edge_det;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end

  // NOTE: default assignment first so the combinational mux never infers a latch.
  always_comb begin
    rd_mux = '0;
    case (addr_e'(address))
      ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_mp3player_soc_input_pio.sv
// Scoreboard bench for mp3player_soc_input_pio: rising, falling and any-edge instances share one bus.
module tb_mp3player_soc_input_pio;

  localparam int W  = 10;
  localparam int SS = 2;
  localparam int DB = 4;
`ifdef MP3PLAYER_SOC_INPUT_PIO_DEBOUNCE_EN
  localparam int IN_LAT = SS + DB + 1;
`else
  localparam int IN_LAT = SS + 1;
`endif

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd_rise, rd_fall, rd_any;
  logic          irq_rise, irq_fall, irq_any;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  mp3player_soc_input_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_rise), .irq(irq_rise));

  mp3player_soc_input_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_fall), .irq(irq_fall));

  mp3player_soc_input_pio #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_any), .irq(irq_any));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick(1);
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    #3;
    exp_q.push_back('{"por_readdata", 32'h0});
    exp_q.push_back('{"por_irq", 32'h0});
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    // Build up live state, then yank reset mid-run.
    bus_write(2'd2, 32'h3FF);
    in_port = 10'h3FF;
    tick(IN_LAT);
    exp_q.push_back('{"prereset_irq", 32'h1});
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    reset_n = 1'b0;
    #1;
    exp_q.push_back('{"midrst_readdata", 32'h0});
    exp_q.push_back('{"midrst_irq", 32'h0});
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    in_port = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    exp_q.push_back('{"postrst_irqmask", 32'h0});
    bus_read(2'd2);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    exp_q.push_back('{"postrst_edgecap", 32'h0});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
  endtask

  task automatic test_level_read;
    exp_t e;
    address = 2'd0;
    for (int k = 1; k <= IN_LAT; k++)
      exp_q.push_back('{$sformatf("level_edge%0d", k), (k < IN_LAT) ? 32'h0 : 32'h0000_02A5});
    in_port = 10'h2A5;
    for (int k = 1; k <= IN_LAT; k++) begin
      tick(1);
      e = exp_q.pop_front(); vectors++;
      if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    end
    exp_q.push_back('{"reserved_read", 32'h0});
    bus_read(2'd1);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    in_port = '0;
    tick(IN_LAT + 1);
    bus_write(2'd3, 32'h3FF);
  endtask

  task automatic test_edge_capture;
    exp_t e;
    bus_write(2'd2, 32'h001);
    in_port = 10'h001;
    tick(IN_LAT);
    exp_q.push_back('{"ec_irq_set", 32'h1});
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    exp_q.push_back('{"ec_set", 32'h001});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    bus_write(2'd3, 32'h000);
    exp_q.push_back('{"ec_w0_irq", 32'h1});
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    exp_q.push_back('{"ec_w0_keep", 32'h001});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    bus_write(2'd3, 32'h001);
    exp_q.push_back('{"ec_w1c_irq", 32'h0});
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    exp_q.push_back('{"ec_w1c_clear", 32'h0});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
  endtask

  task automatic test_simultaneous;
    exp_t e;
    bus_write(2'd2, 32'h008);
    in_port = 10'h009;
    tick(IN_LAT - 1);
    // The W1C write lands on the same edge that captures the bit-3 rise.
    bus_write(2'd3, 32'h008);
    exp_q.push_back('{"sim_irq", 32'h1});
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_rise} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_rise, e.val); end
    exp_q.push_back('{"sim_setwins", 32'h008});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    bus_write(2'd3, 32'h008);
    exp_q.push_back('{"sim_cleared", 32'h0});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
  endtask

  task automatic test_edge_types;
    exp_t e;
    bus_write(2'd3, 32'h3FF);
    bus_write(2'd2, 32'h000);
    in_port = 10'h029;
    tick(IN_LAT);
    exp_q.push_back('{"rise_up", 32'h020});
    exp_q.push_back('{"fall_up", 32'h000});
    exp_q.push_back('{"any_up", 32'h020});
    exp_q.push_back('{"any_up_irq_masked", 32'h0});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    e = exp_q.pop_front(); vectors++;
    if (rd_fall !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_fall, e.val); end
    e = exp_q.pop_front(); vectors++;
    if (rd_any !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_any, e.val); end
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_any} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_any, e.val); end
    bus_write(2'd2, 32'h020);
    exp_q.push_back('{"any_irq_unmasked", 32'h1});
    exp_q.push_back('{"fall_irq_none", 32'h0});
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_any} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_any, e.val); end
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_fall} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_fall, e.val); end
    bus_write(2'd3, 32'h3FF);
    in_port = 10'h009;
    tick(IN_LAT);
    exp_q.push_back('{"rise_down", 32'h000});
    exp_q.push_back('{"fall_down", 32'h020});
    exp_q.push_back('{"any_down", 32'h020});
    exp_q.push_back('{"fall_irq", 32'h1});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    e = exp_q.pop_front(); vectors++;
    if (rd_fall !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_fall, e.val); end
    e = exp_q.pop_front(); vectors++;
    if (rd_any !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_any, e.val); end
    e = exp_q.pop_front(); vectors++;
    if ({31'b0, irq_fall} !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, irq_fall, e.val); end
    bus_write(2'd3, 32'h3FF);
  endtask

  task automatic test_register_widths;
    exp_t e;
    bus_write(2'd2, 32'hFFFF_FFFF);
    exp_q.push_back('{"irqmask_upper_ignored", 32'h3FF});
    bus_read(2'd2);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    bus_write(2'd0, 32'h0000_FFFF);
    bus_write(2'd1, 32'h0000_FFFF);
    exp_q.push_back('{"data_write_ignored", 32'h009});
    bus_read(2'd0);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    exp_q.push_back('{"reserved_write_ignored", 32'h0});
    bus_read(2'd1);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    bus_write(2'd2, 32'h0);
  endtask

`ifdef MP3PLAYER_SOC_INPUT_PIO_DEBOUNCE_EN
  task automatic test_debounce;
    exp_t e;
    in_port = '0;
    tick(IN_LAT + 2);
    bus_write(2'd3, 32'h3FF);
    in_port = 10'h001;
    tick(3);
    in_port = '0;
    tick(IN_LAT + 4);
    exp_q.push_back('{"db_glitch_data", 32'h0});
    bus_read(2'd0);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    exp_q.push_back('{"db_glitch_edge", 32'h0});
    bus_read(2'd3);
    e = exp_q.pop_front(); vectors++;
    if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
    for (int pass = 0; pass < 2; pass++) begin
      address = 2'd0;
      in_port = 10'h001;
      if (pass == 1) begin
        // One-cycle dropout after three high cycles restarts the count.
        tick(3);
        in_port = '0;
        tick(1);
        in_port = 10'h001;
      end
      for (int k = 1; k <= IN_LAT; k++)
        exp_q.push_back('{$sformatf("db_hold%0d_edge%0d", pass, k), (k < IN_LAT) ? 32'h0 : 32'h1});
      for (int k = 1; k <= IN_LAT; k++) begin
        tick(1);
        e = exp_q.pop_front(); vectors++;
        if (rd_rise !== e.val) begin miscompares++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, rd_rise, e.val); end
      end
      in_port = '0;
      tick(IN_LAT + 2);
      bus_write(2'd3, 32'h3FF);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_level_read();
    test_edge_capture();
    test_simultaneous();
    test_edge_types();
    test_register_widths();
`ifdef MP3PLAYER_SOC_INPUT_PIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
